// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: ALU opcodes, arbiter state encodings and default widths
package alu_share_arb_pkg;
  localparam int DW_DEF = 32;
  localparam int OPW_DEF = 5;
  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_SUBU = 5'd2;
  localparam logic [4:0] ALUOp_SLTU = 5'd3;
  localparam logic [4:0] ALUOp_AND  = 5'd4;
  localparam logic [4:0] ALUOp_OR   = 5'd5;
  localparam logic [4:0] ALUOp_XOR  = 5'd6;
  localparam logic [4:0] ALUOp_SLL  = 5'd7;
  localparam logic [4:0] ALUOp_SRL  = 5'd8;
  typedef enum logic [1:0] {
    ARB_FREE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: 2-way round-robin picker honouring a client lock
module alu_arb_rr
  import alu_share_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  arb_state_t state,
  output logic [1:0] grant
);
  always_comb begin
    grant = state == ARB_LOCK0 ? {1'b0, valid[0]} :
            state == ARB_LOCK1 ? {valid[1], 1'b0} :
            &valid ? (last_grant ? 2'b01 : 2'b10) : valid;
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: two-client arbiter/sequencer for the shared ALU, latency 2.
// Optional ALU_ARB_CNT_EN adds saturating transfer/stall counters.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic           r0_lock,
  input  logic [OPW-1:0] r0_op,
  input  logic [DW-1:0]  r0_a,
  input  logic [DW-1:0]  r0_b,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic           r1_lock,
  input  logic [OPW-1:0] r1_op,
  input  logic [DW-1:0]  r1_a,
  input  logic [DW-1:0]  r1_b,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [DW-1:0]  rsp_c,
  output logic           rsp_zero,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_c,
  input  logic           alu_zero
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [15:0]    cnt0,
  output logic [15:0]    cnt1,
  output logic [15:0]    cnt_stall
`endif
);
  arb_state_t state, state_nx;
  logic [1:0] grant;
  logic last_grant, iss_v, iss_id, xfer0, xfer1, xfer, gid, sel_lock;
  alu_arb_rr u_rr (
    .valid({r1_valid, r0_valid}),
    .last_grant(last_grant),
    .state(state),
    .grant(grant)
  );
  // ready is held low while reset is asserted
  assign r0_ready = grant[0] & rstn;
  assign r1_ready = grant[1] & rstn;
  assign xfer0 = r0_valid & r0_ready;
  assign xfer1 = r1_valid & r1_ready;
  assign xfer = xfer0 | xfer1;
  assign gid = xfer1;
  assign sel_lock = gid ? r1_lock : r0_lock;
  always_comb begin
    state_nx = !xfer ? state : !sel_lock ? ARB_FREE : gid ? ARB_LOCK1 : ARB_LOCK0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ARB_FREE;
      last_grant <= 1'b1;
      iss_v <= 1'b0;
      iss_id <= 1'b0;
      alu_op <= OPW'(ALUOp_NOP);
      alu_a <= '0;
      alu_b <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_c <= '0;
      rsp_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) last_grant <= gid;
      iss_v <= xfer;
      iss_id <= gid;
      alu_op <= !xfer ? OPW'(ALUOp_NOP) : gid ? r1_op : r0_op;
      if (xfer) begin
        alu_a <= gid ? r1_a : r0_a;
        alu_b <= gid ? r1_b : r0_b;
      end
      rsp0_valid <= iss_v & !iss_id;
      rsp1_valid <= iss_v & iss_id;
      if (iss_v) begin
        rsp_c <= alu_c;
        rsp_zero <= alu_zero;
      end
    end
  end
`ifdef ALU_ARB_CNT_EN
  logic stall;
  assign stall = (r0_valid & !r0_ready) | (r1_valid & !r1_ready);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt_stall <= '0;
    end else begin
      if (xfer0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (xfer1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
      if (stall && cnt_stall != 16'hFFFF) cnt_stall <= cnt_stall + 16'd1;
    end
  end
`endif
endmodule
